// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Redirects (jump over branch) retarget the PC; a misaligned target vectors to EXC_VEC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    input  logic        id_ready_i,
    output logic        exc_misalign_o,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: imem request is taken when imem_req_o & imem_gnt_i are high on a
    // rising edge; decode takes an instruction when if_valid_o & id_ready_i are high.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_d;
    logic        if_valid_d;
    logic [31:0] if_instr_d, if_pc_d;
    logic        exc_d;
    logic        redir;
    logic [31:0] tgt;
    logic        misalign;
    logic [31:0] redir_pc;

    assign redir       = (state_q != IDLE) && (jmp_i || br_taken_i);
    assign tgt         = jmp_i ? jmp_target_i : br_target_i;
    assign misalign    = redir && (tgt[1:0] != 2'b00);
    assign redir_pc    = misalign ? EXC_VEC : tgt;
    assign imem_req_o  = (state_q == REQ) && !stall_i;
    assign imem_addr_o = pc_o;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        pc_d       = pc_o;
        if_valid_d = if_valid_o;
        if_instr_d = if_instr_o;
        if_pc_d    = if_pc_o;
        exc_d      = misalign;

        if (redir) pc_d = redir_pc;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A grant coinciding with a redirect fetches the stale PC; kill its response.
                if (imem_req_o && imem_gnt_i) begin
                    state_d = WAIT;
                    kill_d  = redir;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (redir || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        if_instr_d = imem_rdata_i;
                        if_pc_d    = pc_o;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (id_ready_i && !stall_i) begin
                    if_valid_d = 1'b0;
                    pc_d       = pc_plus4_i;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            kill_q         <= 1'b0;
            pc_o           <= RESET_PC;
            if_valid_o     <= 1'b0;
            if_instr_o     <= 32'h0;
            if_pc_o        <= 32'h0;
            exc_misalign_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_q         <= kill_d;
            pc_o           <= pc_d;
            if_valid_o     <= if_valid_d;
            if_instr_o     <= if_instr_d;
            if_pc_o        <= if_pc_d;
            exc_misalign_o <= exc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: zero-latency memory model, external +4 adder,
// expected fetch PCs held in a queue and compared as instructions reach decode.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        exc_misalign;
    logic [1:0]  dbg_state;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    logic        pend;
    logic [31:0] pend_a;
    logic        mem_hold;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_o           (pc_o),
        .pc_plus4_i     (pc_plus4),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .jmp_i          (jmp),
        .jmp_target_i   (jmp_target),
        .stall_i        (stall),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_gnt_i     (imem_gnt),
        .imem_rvalid_i  (imem_rvalid),
        .imem_rdata_i   (imem_rdata),
        .if_valid_o     (if_valid),
        .if_instr_o     (if_instr),
        .if_pc_o        (if_pc),
        .id_ready_i     (id_ready),
        .exc_misalign_o (exc_misalign),
        .dbg_state_o    (dbg_state)
    );

    // external adder and always-ready memory port
    assign pc_plus4 = pc_o + 32'd4;
    assign imem_gnt = imem_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: record a grant, then present its response after the edge
    task automatic cyc();
        logic        g;
        logic [31:0] a;
        #1;
        g = imem_req & imem_gnt;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (g) begin
            pend   = 1'b1;
            pend_a = a;
        end
        if (pend && !mem_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_a);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic expect_fetch();
        logic [31:0] e;
        int n;
        e = exp_q.pop_front();
        n = 0;
        while (!if_valid && n < 20) begin
            cyc();
            n++;
        end
        check("fetch_valid", {31'h0, if_valid}, 32'h1);
        check("fetch_pc", if_pc, e);
        check("fetch_instr", if_instr, mem_word(e));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        jmp         = 1'b0;
        jmp_target  = 32'h0;
        stall       = 1'b0;
        id_ready    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend        = 1'b0;
        pend_a      = 32'h0;
        mem_hold    = 1'b0;

        cyc();
        cyc();
        check("rst_pc", pc_o, 32'h0000_3000);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_ifpc", if_pc, 32'h0);
        check("rst_exc", {31'h0, exc_misalign}, 32'h0);

        rst_n = 1'b1;
        #1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        cyc();
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0000_3000);

        // sequential fetch
        exp_q.push_back(32'h0000_3000);
        exp_q.push_back(32'h0000_3004);
        exp_q.push_back(32'h0000_3008);
        for (int i = 0; i < 3; i++) begin
            expect_fetch();
            cyc();
        end

        // decode back-pressure
        id_ready = 1'b0;
        exp_q.push_back(32'h0000_300C);
        expect_fetch();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("bp_valid", {31'h0, if_valid}, 32'h1);
            check("bp_ifpc", if_pc, 32'h0000_300C);
            check("bp_instr", if_instr, mem_word(32'h0000_300C));
            check("bp_pc", pc_o, 32'h0000_300C);
        end
        id_ready = 1'b1;
        cyc();
        check("bp_accept_valid", {31'h0, if_valid}, 32'h0);
        check("bp_accept_pc", pc_o, 32'h0000_3010);

        // jump wins over branch while waiting on memory; pending response is dropped
        mem_hold = 1'b1;
        cyc();
        jmp        = 1'b1;
        jmp_target = 32'h0000_3100;
        br_taken   = 1'b1;
        br_target  = 32'h0000_3200;
        cyc();
        jmp      = 1'b0;
        br_taken = 1'b0;
        check("jmp_pc", pc_o, 32'h0000_3100);
        check("jmp_req", {31'h0, imem_req}, 32'h0);
        mem_hold = 1'b0;
        exp_q.push_back(32'h0000_3100);
        expect_fetch();

        // misaligned branch squashes the held instruction
        br_taken  = 1'b1;
        br_target = 32'h0000_3006;
        cyc();
        br_taken = 1'b0;
        check("mis_exc", {31'h0, exc_misalign}, 32'h1);
        check("mis_pc", pc_o, 32'h0000_4180);
        check("mis_squash", {31'h0, if_valid}, 32'h0);
        cyc();
        check("mis_exc_pulse", {31'h0, exc_misalign}, 32'h0);
        exp_q.push_back(32'h0000_4180);
        expect_fetch();

        // stall in REQ
        cyc();
        stall = 1'b1;
        #1;
        check("stall_req0", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("stall_req", {31'h0, imem_req}, 32'h0);
            check("stall_pc", pc_o, 32'h0000_4184);
        end
        stall = 1'b0;
        #1;
        check("stall_resume", {31'h0, imem_req}, 32'h1);
        exp_q.push_back(32'h0000_4184);
        expect_fetch();

        // reset while waiting on memory
        mem_hold = 1'b1;
        cyc();
        cyc();
        check("pre_rst_pc", pc_o, 32'h0000_4188);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc_o, 32'h0000_3000);
        check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
        check("mid_rst_ifpc", if_pc, 32'h0);
        check("mid_rst_instr", if_instr, 32'h0);
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        pend     = 1'b0;
        mem_hold = 1'b0;
        cyc();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        #1;
        check("rel_idle_req", {31'h0, imem_req}, 32'h0);
        cyc();
        check("rel_req", {31'h0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, 32'h0000_3000);
        check("rel_stale", {31'h0, if_valid}, 32'h0);
        exp_q.push_back(32'h0000_3000);
        expect_fetch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
